// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle: the arbiter is the master, the memory model/controller the slave.
// Handshake: mem_req with mem_we/mem_addr/mem_wdata stays stable until mem_ack; mem_ack and mem_rdata count only while mem_req is high.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, with
// address checks, round-robin tie-breaking and a watchdog that turns a hung access into a fault.
module mem_port_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] INSTR_LIMIT = 32'h0000_FFFC,
  parameter logic [ADDR_W-1:0] DATA_BASE   = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] DATA_LIMIT  = 32'h0001_FFFC,
  parameter int                TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              wait_instr,
  output logic              instr_segv,
  input  logic              data_ld,
  input  logic              data_st,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              wait_data,
  output logic              data_segv,
  mem_port_arbiter_if.master mem,
  output logic [2:0]        dbg_state
);

  localparam int            CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    MEM    = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              grant_data_q;
  logic              both_q;
  logic              last_data_q;
  logic [CW-1:0]     cnt_q;

  logic data_any, any_req, grant_data, fault_chk, timed_out;
  logic mem_req_c, segv_c;

  assign data_any   = data_ld | data_st;
  assign any_req    = instr_req | data_any;
  // On a tie the requester that did not win last time is served.
  assign grant_data = data_any & (~instr_req | ~last_data_q);
  assign timed_out  = (cnt_q == TO);

  assign fault_chk = (addr_q[1:0] != 2'b00)
                   | (~grant_data_q & (addr_q > INSTR_LIMIT))
                   | (grant_data_q & ((addr_q < DATA_BASE) | (addr_q > DATA_LIMIT) | both_q));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_req_c = 1'b0;
    segv_c    = 1'b0;
    case (state)
      IDLE:  if (any_req) state_n = CHECK;
      CHECK: begin
        if (fault_chk) begin
          segv_c  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = MEM;
        end
      end
      MEM: begin
        // The watchdog cycle itself has mem_req low, so a late ack there is ignored.
        if (timed_out) begin
          segv_c  = 1'b1;
          state_n = IDLE;
        end else begin
          mem_req_c = 1'b1;
          if (mem.mem_ack) state_n = grant_data_q ? DONE_D : DONE_I;
        end
      end
      DONE_I, DONE_D: state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      grant_data_q <= 1'b0;
      both_q       <= 1'b0;
      last_data_q  <= 1'b0;
      cnt_q        <= '0;
      instr_rdata  <= '0;
      data_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_data_q <= grant_data;
        last_data_q  <= grant_data;
        addr_q       <= grant_data ? data_addr : instr_addr;
        wdata_q      <= grant_data ? data_wdata : '0;
        we_q         <= grant_data & data_st;
        both_q       <= grant_data & data_ld & data_st;
      end
      if (state == CHECK)
        cnt_q <= '0;
      else if (state == MEM && !mem.mem_ack && !timed_out)
        cnt_q <= cnt_q + 1'b1;
      if (mem_req_c && mem.mem_ack) begin
        if (!grant_data_q)  instr_rdata <= mem.mem_rdata;
        else if (!we_q)     data_rdata  <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign instr_segv = segv_c & ~grant_data_q;
  assign data_segv  = segv_c &  grant_data_q;
  assign wait_instr = instr_req & (state != DONE_I) & ~instr_segv;
  assign wait_data  = data_any  & (state != DONE_D) & ~data_segv;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for the watchdog, reset during an access and a withdrawn fetch.
module tb_mem_port_arbiter;

  localparam logic [2:0] S_I  = 3'd0;
  localparam logic [2:0] S_C  = 3'd1;
  localparam logic [2:0] S_M  = 3'd2;
  localparam logic [2:0] S_DI = 3'd3;
  localparam logic [2:0] S_DD = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic [31:0] instr_rdata;
  logic        wait_instr, instr_segv;
  logic        data_ld = 1'b0, data_st = 1'b0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [31:0] data_rdata;
  logic        wait_data, data_segv;
  logic [2:0]  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_rdata(instr_rdata),
    .wait_instr (wait_instr),
    .instr_segv (instr_segv),
    .data_ld    (data_ld),
    .data_st    (data_st),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .wait_data  (wait_data),
    .data_segv  (data_segv),
    .mem        (mem_bus),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dld, dst;
    logic [31:0] daddr, dwdata;
    logic        ack;
    logic [31:0] rdata;
    logic [2:0]  st;
    logic        mreq, we;
    logic [31:0] maddr, mwdata;
    logic        wi, wd, is, ds;
    logic [31:0] ir, dr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic ireq, input logic [31:0] iaddr, input logic dld, input logic dst,
    input logic [31:0] daddr, input logic [31:0] dwdata, input logic ack, input logic [31:0] rdata,
    input logic [2:0] st, input logic mreq, input logic we, input logic [31:0] maddr,
    input logic [31:0] mwdata, input logic wi, input logic wd, input logic is, input logic ds,
    input logic [31:0] ir, input logic [31:0] dr);
    vec_t r;
    r.ireq = ireq; r.iaddr = iaddr; r.dld = dld; r.dst = dst; r.daddr = daddr; r.dwdata = dwdata;
    r.ack = ack; r.rdata = rdata; r.st = st; r.mreq = mreq; r.we = we; r.maddr = maddr;
    r.mwdata = mwdata; r.wi = wi; r.wd = wd; r.is = is; r.ds = ds; r.ir = ir; r.dr = dr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ireq, input logic [31:0] iaddr, input logic dld, input logic dst,
                        input logic [31:0] daddr, input logic [31:0] dwdata,
                        input logic ack, input logic [31:0] rdata);
    instr_req  = ireq;  instr_addr = iaddr;
    data_ld    = dld;   data_st    = dst;
    data_addr  = daddr; data_wdata = dwdata;
    mem_bus.mem_ack   = ack;
    mem_bus.mem_rdata = rdata;
  endtask

  // Drive at posedge+1, sample at the following negedge.
  task automatic cyc(input logic ireq, input logic [31:0] iaddr, input logic dld, input logic dst,
                     input logic [31:0] daddr, input logic [31:0] dwdata,
                     input logic ack, input logic [31:0] rdata);
    @(posedge clk); #1;
    set_in(ireq, iaddr, dld, dst, daddr, dwdata, ack, rdata);
    @(negedge clk);
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;

    // Single fetch, zero-wait memory
    tbl.push_back(v(1,'h10,0,0,0,0,0,0,                 S_I ,0,0,0,0, 1,0,0,0, 0,0));
    tbl.push_back(v(1,'h10,0,0,0,0,0,0,                 S_C ,0,0,0,0, 1,0,0,0, 0,0));
    tbl.push_back(v(1,'h10,0,0,0,0,1,'hDEADBEEF,        S_M ,1,0,'h10,0, 1,0,0,0, 0,0));
    tbl.push_back(v(1,'h10,0,0,0,0,0,0,                 S_DI,0,0,0,0, 0,0,0,0, 'hDEADBEEF,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'hDEADBEEF,0));
    // Contention: data, instr, data, instr
    tbl.push_back(v(1,'h20,1,0,'h10000,0,0,0,           S_I ,0,0,0,0, 1,1,0,0, 'hDEADBEEF,0));
    tbl.push_back(v(1,'h20,1,0,'h10000,0,0,0,           S_C ,0,0,0,0, 1,1,0,0, 'hDEADBEEF,0));
    tbl.push_back(v(1,'h20,1,0,'h10000,0,1,'h11112222,  S_M ,1,0,'h10000,0, 1,1,0,0, 'hDEADBEEF,0));
    tbl.push_back(v(1,'h20,1,0,'h10000,0,0,0,           S_DD,0,0,0,0, 1,0,0,0, 'hDEADBEEF,'h11112222));
    tbl.push_back(v(1,'h20,1,0,'h10004,0,0,0,           S_I ,0,0,0,0, 1,1,0,0, 'hDEADBEEF,'h11112222));
    tbl.push_back(v(1,'h20,1,0,'h10004,0,0,0,           S_C ,0,0,0,0, 1,1,0,0, 'hDEADBEEF,'h11112222));
    tbl.push_back(v(1,'h20,1,0,'h10004,0,1,'h33334444,  S_M ,1,0,'h20,0, 1,1,0,0, 'hDEADBEEF,'h11112222));
    tbl.push_back(v(1,'h20,1,0,'h10004,0,0,0,           S_DI,0,0,0,0, 0,1,0,0, 'h33334444,'h11112222));
    tbl.push_back(v(1,'h24,1,0,'h10004,0,0,0,           S_I ,0,0,0,0, 1,1,0,0, 'h33334444,'h11112222));
    tbl.push_back(v(1,'h24,1,0,'h10004,0,0,0,           S_C ,0,0,0,0, 1,1,0,0, 'h33334444,'h11112222));
    tbl.push_back(v(1,'h24,1,0,'h10004,0,1,'h55556666,  S_M ,1,0,'h10004,0, 1,1,0,0, 'h33334444,'h11112222));
    tbl.push_back(v(1,'h24,1,0,'h10004,0,0,0,           S_DD,0,0,0,0, 1,0,0,0, 'h33334444,'h55556666));
    tbl.push_back(v(1,'h24,0,0,0,0,0,0,                 S_I ,0,0,0,0, 1,0,0,0, 'h33334444,'h55556666));
    tbl.push_back(v(1,'h24,0,0,0,0,0,0,                 S_C ,0,0,0,0, 1,0,0,0, 'h33334444,'h55556666));
    tbl.push_back(v(1,'h24,0,0,0,0,1,'h77778888,        S_M ,1,0,'h24,0, 1,0,0,0, 'h33334444,'h55556666));
    tbl.push_back(v(1,'h24,0,0,0,0,0,0,                 S_DI,0,0,0,0, 0,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h77778888,'h55556666));
    // Faults and range boundaries
    tbl.push_back(v(1,'h10002,0,0,0,0,0,0,              S_I ,0,0,0,0, 1,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(1,'h10002,0,0,0,0,0,0,              S_C ,0,0,0,0, 0,0,1,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,1,0,'h20000,0,0,0,              S_I ,0,0,0,0, 0,1,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,1,0,'h20000,0,0,0,              S_C ,0,0,0,0, 0,0,0,1, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,1,1,'h10008,'hAAAA,0,0,         S_I ,0,0,0,0, 0,1,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,1,1,'h10008,'hAAAA,0,0,         S_C ,0,0,0,0, 0,0,0,1, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,1,'hFFFFFFFC,0,0,0,           S_I ,0,0,0,0, 0,1,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,1,'hFFFFFFFC,0,0,0,           S_C ,0,0,0,0, 0,0,0,1, 'h77778888,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(1,'hFFFC,0,0,0,0,0,0,               S_I ,0,0,0,0, 1,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(1,'hFFFC,0,0,0,0,0,0,               S_C ,0,0,0,0, 1,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(1,'hFFFC,0,0,0,0,1,'h9999AAAA,      S_M ,1,0,'hFFFC,0, 1,0,0,0, 'h77778888,'h55556666));
    tbl.push_back(v(1,'hFFFC,0,0,0,0,0,0,               S_DI,0,0,0,0, 0,0,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,1,0,'hFFFC,0,0,0,               S_I ,0,0,0,0, 0,1,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,1,0,'hFFFC,0,0,0,               S_C ,0,0,0,0, 0,0,0,1, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,1,'h1FFFC,'hCAFEF00D,0,0,     S_I ,0,0,0,0, 0,1,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,1,'h1FFFC,'hCAFEF00D,0,0,     S_C ,0,0,0,0, 0,1,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,1,'h1FFFC,'hCAFEF00D,1,'h5A5A5A5A, S_M,1,1,'h1FFFC,'hCAFEF00D, 0,1,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,1,'h1FFFC,'hCAFEF00D,0,0,     S_DD,0,0,0,0, 0,0,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(1,'h10000,0,0,0,0,0,0,              S_I ,0,0,0,0, 1,0,0,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(1,'h10000,0,0,0,0,0,0,              S_C ,0,0,0,0, 0,0,1,0, 'h9999AAAA,'h55556666));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                    S_I ,0,0,0,0, 0,0,0,0, 'h9999AAAA,'h55556666));

    // Reset state
    repeat (2) cyc(0,0,0,0,0,0,0,0);
    chk("rst state", dbg_state, S_I);
    chk("rst mem_req", mem_bus.mem_req, 0);
    chk("rst mem_we", mem_bus.mem_we, 0);
    chk("rst mem_addr", mem_bus.mem_addr, 0);
    chk("rst mem_wdata", mem_bus.mem_wdata, 0);
    chk("rst instr_rdata", instr_rdata, 0);
    chk("rst data_rdata", data_rdata, 0);
    chk("rst segv", {30'd0, instr_segv, data_segv}, 0);

    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      cyc(t.ireq, t.iaddr, t.dld, t.dst, t.daddr, t.dwdata, t.ack, t.rdata);
      chk($sformatf("v%0d state", i), dbg_state, t.st);
      chk($sformatf("v%0d mem_req", i), mem_bus.mem_req, t.mreq);
      chk($sformatf("v%0d wait_instr", i), wait_instr, t.wi);
      chk($sformatf("v%0d wait_data", i), wait_data, t.wd);
      chk($sformatf("v%0d instr_segv", i), instr_segv, t.is);
      chk($sformatf("v%0d data_segv", i), data_segv, t.ds);
      chk($sformatf("v%0d instr_rdata", i), instr_rdata, t.ir);
      chk($sformatf("v%0d data_rdata", i), data_rdata, t.dr);
      if (t.mreq) begin
        chk($sformatf("v%0d mem_we", i), mem_bus.mem_we, t.we);
        chk($sformatf("v%0d mem_addr", i), mem_bus.mem_addr, t.maddr);
        if (t.we) chk($sformatf("v%0d mem_wdata", i), mem_bus.mem_wdata, t.mwdata);
      end
    end

    // Watchdog: store that is never acknowledged
    begin
      int   hi = 0;
      logic seen = 1'b0, we_ok = 1'b1, seg_mreq = 1'b1, seg_wd = 1'b1;
      for (int k = 0; k < 400 && !seen; k++) begin
        cyc(0,0,0,1,'h10004,'h12345678,0,0);
        if (mem_bus.mem_req) begin
          hi++;
          if (!mem_bus.mem_we || mem_bus.mem_addr != 32'h10004) we_ok = 1'b0;
        end
        if (data_segv) begin
          seen = 1'b1; seg_mreq = mem_bus.mem_req; seg_wd = wait_data;
        end
      end
      chk("timeout segv seen", seen, 1);
      chk("timeout mem_req cycles", hi, 255);
      chk("timeout we/addr held", we_ok, 1);
      chk("timeout mem_req at segv", seg_mreq, 0);
      chk("timeout wait_data at segv", seg_wd, 0);
      cyc(0,0,0,0,0,0,0,0);
      chk("timeout then idle", dbg_state, S_I);
      chk("timeout single pulse", data_segv, 0);
    end

    // Reset while a load is in MEM; late ack afterwards must be ignored
    begin
      logic found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        cyc(0,0,1,0,'h10010,0,0,0);
        found = mem_bus.mem_req;
      end
      chk("rstmem reached MEM", found, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      set_in(0,0,0,0,0,0,0,0);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(0,0,0,0,0,0,1,'hBAD0BAD0);
      @(negedge clk);
      chk("rstmem mem_req dropped", mem_bus.mem_req, 0);
      chk("rstmem state", dbg_state, S_I);
      for (int k = 0; k < 3; k++) begin
        cyc(0,0,0,0,0,0,1,'hBAD0BAD0);
        chk($sformatf("rstmem data_rdata %0d", k), data_rdata, 0);
        chk($sformatf("rstmem segv %0d", k), {30'd0, instr_segv, data_segv}, 0);
      end
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        cyc(1,'h30,1,0,'h10014,0,0,0);
        found = mem_bus.mem_req;
      end
      chk("rstmem tie reached MEM", found, 1);
      chk("rstmem tie to data", mem_bus.mem_addr, 'h10014);
      cyc(1,'h30,1,0,'h10014,0,1,'h600D600D);
      cyc(1,'h30,1,0,'h10014,0,0,0);
      chk("rstmem tie done", dbg_state, S_DD);
      chk("rstmem tie rdata", data_rdata, 'h600D600D);
      cyc(0,0,0,0,0,0,0,0);
    end

    // Fetch withdrawn during MEM; ack arrives later
    begin
      logic found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        cyc(1,'h40,0,0,0,0,0,0);
        found = mem_bus.mem_req;
      end
      chk("wd reached MEM", found, 1);
      for (int k = 0; k < 3; k++) begin
        cyc(0,0,0,0,0,0,(k == 2),'h0BADF00D);
        chk($sformatf("wd mem_req %0d", k), mem_bus.mem_req, 1);
        chk($sformatf("wd wait_instr %0d", k), wait_instr, 0);
        chk($sformatf("wd segv %0d", k), instr_segv, 0);
      end
      cyc(0,0,0,0,0,0,0,0);
      chk("wd done state", dbg_state, S_DI);
      chk("wd instr_rdata", instr_rdata, 'h0BADF00D);
      chk("wd wait_instr done", wait_instr, 0);
      chk("wd segv done", instr_segv, 0);
      cyc(0,0,0,0,0,0,0,0);
      chk("wd back idle", dbg_state, S_I);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
